// File: rtl/leaf_packet_rx.sv
// leaf_packet_rx: BFT leaf receiver with per-port FWFT FIFOs and credit return; define LEAF_PACKET_RX_DROP_CNT_EN to add a saturating drop_cnt output
module leaf_packet_rx #(
  parameter int PACKET_BITS = 49,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_IN_PORTS = 1,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int LEAF_ID = 0
) (
  input  logic                                 clk_400,
  input  logic                                 reset_400,
  input  logic [PACKET_BITS-1:0]               din_leaf_bft2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  output logic [NUM_IN_PORTS-1:0]              vld_interface2user,
  input  logic [NUM_IN_PORTS-1:0]              ack_user2interface,
  output logic                                 credit_vld,
  output logic [NUM_PORT_BITS-1:0]             credit_port,
  output logic [NUM_IN_PORTS-1:0]              overflow
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
  ,
  output logic [15:0]                          drop_cnt
`endif
);
  localparam int CW = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam int AW = FIFO_DEPTH_BITS + 1;
  localparam int PB = PACKET_BITS - 2 - NUM_LEAF_BITS;
  logic [NUM_LEAF_BITS-1:0] pkt_leaf;
  logic [NUM_PORT_BITS-1:0] pkt_port, sel;
  logic [PAYLOAD_BITS-1:0] pkt_data;
  logic pkt_vld, accept, unused_addr;
  logic [NUM_IN_PORTS-1:0] pending, srv, drop;
  assign pkt_vld = din_leaf_bft2interface[PACKET_BITS-1];
  assign pkt_leaf = din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS];
  assign pkt_port = din_leaf_bft2interface[PB -: NUM_PORT_BITS];
  assign unused_addr = ^din_leaf_bft2interface[PB-NUM_PORT_BITS -: NUM_ADDR_BITS];
  assign pkt_data = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  assign accept = pkt_vld && pkt_leaf == NUM_LEAF_BITS'(LEAF_ID) && pkt_port != '0
                  && pkt_port <= NUM_PORT_BITS'(NUM_IN_PORTS);
  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_port
    logic [PAYLOAD_BITS-1:0] mem [2**FIFO_DEPTH_BITS];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [1:0] pend;
    logic ovf, hit, full, pop, push, ev;
    assign hit = accept && pkt_port == NUM_PORT_BITS'(p + 1);
    assign full = (wp ^ rp) == {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    assign pop = vld_interface2user[p] && ack_user2interface[p];
    assign push = hit && (!full || pop);
    assign ev = pop && cnt == CW'(FREESPACE_UPDATE_SIZE - 1);
    assign drop[p] = hit && full && !pop;
    assign pending[p] = pend != 2'd0;
    assign overflow[p] = ovf;
    assign vld_interface2user[p] = wp != rp;
    assign dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rp[FIFO_DEPTH_BITS-1:0]];
    always_ff @(posedge clk_400)
      if (push) mem[wp[FIFO_DEPTH_BITS-1:0]] <= pkt_data;
    always_ff @(posedge clk_400)
      if (reset_400) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        pend <= 2'd0;
        ovf <= 1'b0;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(pop);
        cnt <= ev ? '0 : cnt + CW'(pop);
        pend <= (pend == 2'd2 && !srv[p]) ? 2'd2 : pend + 2'(ev) - 2'(srv[p]);
        ovf <= ovf | drop[p];
      end
  end
  assign srv = pending & ~(pending - NUM_IN_PORTS'(1));
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) sel = srv[i] ? NUM_PORT_BITS'(i + 1) : sel;
  end
  always_ff @(posedge clk_400)
    if (reset_400) begin
      credit_vld <= 1'b0;
      credit_port <= '0;
    end else begin
      credit_vld <= |pending;
      credit_port <= sel;
    end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
  always_ff @(posedge clk_400)
    if (reset_400) drop_cnt <= '0;
    else if (((pkt_vld && !accept) || |drop) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_leaf_packet_rx.sv
// tb_leaf_packet_rx: directed and randomized checks of leaf_packet_rx against a queue-based model
module tb_leaf_packet_rx;
  logic clk_400 = 1'b0;
  logic reset_400 = 1'b1;
  logic [48:0] din = '0;
  logic [63:0] dout;
  logic [1:0] vld, ovf;
  logic [1:0] ack = 2'b00;
  logic credit_vld;
  logic [3:0] credit_port;
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk_400 = ~clk_400;
  leaf_packet_rx #(.NUM_IN_PORTS(2), .FREESPACE_UPDATE_SIZE(4), .LEAF_ID(3)) dut (
    .clk_400(clk_400),
    .reset_400(reset_400),
    .din_leaf_bft2interface(din),
    .dout_leaf_interface2user(dout),
    .vld_interface2user(vld),
    .ack_user2interface(ack),
    .credit_vld(credit_vld),
    .credit_port(credit_port),
    .overflow(ovf)
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );
  function automatic logic [48:0] pkt(logic v, logic [4:0] l, logic [3:0] p, logic [31:0] d);
    logic [6:0] a;
    a = 7'($urandom);
    return {v, l, p, a, d};
  endfunction
  task automatic tick();
    @(posedge clk_400);
    #1;
  endtask
  task automatic do_reset();
    reset_400 = 1'b1;
    din = '0;
    ack = 2'b00;
    tick();
    reset_400 = 1'b0;
  endtask
  task automatic test_reset();
    reset_400 = 1'b1;
    din = pkt(1'b1, 5'd3, 4'd1, 32'h1234_5678);
    ack = 2'b11;
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL reset_vld got %b want 00", vld); end
    total++; if (ovf !== 2'b00) begin bad++; $display("FAIL reset_ovf got %b want 00", ovf); end
    total++; if (credit_vld !== 1'b0) begin bad++; $display("FAIL reset_credit_vld got %b want 0", credit_vld); end
    total++; if (credit_port !== 4'd0) begin bad++; $display("FAIL reset_credit_port got %0d want 0", credit_port); end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
`endif
    reset_400 = 1'b0;
    din = '0;
    ack = 2'b00;
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL reset_nostore got %b want 00", vld); end
  endtask
  task automatic test_basic();
    do_reset();
    din = pkt(1'b1, 5'd3, 4'd1, 32'hDEAD_BEEF);
    tick();
    din = '0;
    total++; if (vld !== 2'b01) begin bad++; $display("FAIL basic_vld got %b want 01", vld); end
    total++; if (dout[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_data got %h want deadbeef", dout[31:0]); end
    repeat (3) tick();
    total++; if (vld !== 2'b01 || dout[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_hold got %b/%h want 01/deadbeef", vld, dout[31:0]); end
    ack = 2'b10;
    tick();
    total++; if (vld !== 2'b01) begin bad++; $display("FAIL basic_ack_other got %b want 01", vld); end
    ack = 2'b01;
    tick();
    ack = 2'b00;
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL basic_pop got %b want 00", vld); end
  endtask
  task automatic test_discard();
    do_reset();
    din = pkt(1'b1, 5'd4, 4'd1, 32'h1111_1111);
    tick();
    din = '0;
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL discard_leaf got %b want 00", vld); end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL discard_cnt1 got %0d want 1", drop_cnt); end
`endif
    din = pkt(1'b1, 5'd3, 4'd0, 32'h2222_2222);
    tick();
    din = pkt(1'b1, 5'd3, 4'd3, 32'h3333_3333);
    tick();
    din = pkt(1'b0, 5'd3, 4'd1, 32'h4444_4444);
    tick();
    din = '0;
    tick();
    total++; if (vld !== 2'b00 || ovf !== 2'b00) begin bad++; $display("FAIL discard_port got %b/%b want 00/00", vld, ovf); end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL discard_cnt3 got %0d want 3", drop_cnt); end
`endif
  endtask
  task automatic test_overflow();
    logic [31:0] w [5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w[k] = $urandom;
      din = pkt(1'b1, 5'd3, 4'd1, w[k]);
      tick();
      if (k == 3) begin
        total++; if (ovf !== 2'b00) begin bad++; $display("FAIL ovf_early got %b want 00", ovf); end
      end
    end
    din = '0;
    total++; if (ovf !== 2'b01) begin bad++; $display("FAIL ovf_flag got %b want 01", ovf); end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
`endif
    ack = 2'b01;
    for (int k = 0; k < 4; k++) begin
      total++; if (vld[0] !== 1'b1 || dout[31:0] !== w[k]) begin bad++; $display("FAIL ovf_order%0d got %b/%h want 1/%h", k, vld[0], dout[31:0], w[k]); end
      tick();
    end
    ack = 2'b00;
    total++; if (vld !== 2'b00 || ovf !== 2'b01) begin bad++; $display("FAIL ovf_drained got %b/%b want 00/01", vld, ovf); end
  endtask
  task automatic test_full_pushpop();
    logic [31:0] w [5];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w[k] = $urandom;
      din = pkt(1'b1, 5'd3, 4'd2, w[k]);
      tick();
    end
    w[4] = $urandom;
    din = pkt(1'b1, 5'd3, 4'd2, w[4]);
    ack = 2'b10;
    tick();
    din = '0;
    ack = 2'b00;
    total++; if (ovf !== 2'b00) begin bad++; $display("FAIL pushpop_ovf got %b want 00", ovf); end
    ack = 2'b10;
    for (int k = 1; k < 5; k++) begin
      total++; if (vld[1] !== 1'b1 || dout[63:32] !== w[k]) begin bad++; $display("FAIL pushpop_word%0d got %b/%h want 1/%h", k, vld[1], dout[63:32], w[k]); end
      tick();
    end
    ack = 2'b00;
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL pushpop_empty got %b want 00", vld); end
  endtask
  task automatic test_credit_pair();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      din = pkt(1'b1, 5'd3, 4'(k % 2 + 1), $urandom);
      tick();
    end
    din = '0;
    ack = 2'b11;
    repeat (4) begin
      tick();
      total++; if (credit_vld !== 1'b0) begin bad++; $display("FAIL credit_early got %b want 0", credit_vld); end
    end
    ack = 2'b00;
    tick();
    total++; if (credit_vld !== 1'b1 || credit_port !== 4'd1) begin bad++; $display("FAIL credit_first got %b/%0d want 1/1", credit_vld, credit_port); end
    tick();
    total++; if (credit_vld !== 1'b1 || credit_port !== 4'd2) begin bad++; $display("FAIL credit_second got %b/%0d want 1/2", credit_vld, credit_port); end
    tick();
    total++; if (credit_vld !== 1'b0) begin bad++; $display("FAIL credit_done got %b want 0", credit_vld); end
  endtask
  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      din = pkt(1'b1, 5'd3, 4'd1, $urandom);
      tick();
    end
    din = '0;
    ack = 2'b01;
    tick();
    reset_400 = 1'b1;
    tick();
    reset_400 = 1'b0;
    ack = 2'b00;
    total++; if (vld !== 2'b00 || credit_vld !== 1'b0) begin bad++; $display("FAIL midreset_vld got %b/%b want 00/0", vld, credit_vld); end
    for (int k = 0; k < 4; k++) begin
      din = pkt(1'b1, 5'd3, 4'd1, $urandom);
      tick();
    end
    din = '0;
    ack = 2'b01;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (credit_vld) n++;
    end
    ack = 2'b00;
    total++; if (n != 1) begin bad++; $display("FAIL midreset_credits got %0d want 1", n); end
  endtask
  task automatic test_random();
    logic [31:0] mq [2][$];
    int cons [2];
    int cr [2];
    logic [1:0] movf;
    int drops;
    logic v;
    logic [4:0] l;
    logic [3:0] p;
    logic [31:0] d;
    do_reset();
    cons = '{0, 0};
    cr = '{0, 0};
    movf = 2'b00;
    drops = 0;
    for (int c = 0; c < 1600; c++) begin
      if (c < 1590) begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 7) != 0) ? 5'd3 : 5'($urandom);
        p = 4'($urandom_range(0, 3));
        d = $urandom;
        ack = 2'($urandom);
      end else begin
        v = 1'b0;
        l = 5'd0;
        p = 4'd0;
        d = 32'd0;
        ack = 2'b11;
      end
      din = pkt(v, l, p, d);
      for (int i = 0; i < 2; i++)
        if (mq[i].size() != 0 && ack[i]) begin
          void'(mq[i].pop_front());
          cons[i]++;
        end
      if (v) begin
        if (l == 5'd3 && p >= 4'd1 && p <= 4'd2) begin
          if (mq[p-1].size() < 4) mq[p-1].push_back(d);
          else begin
            movf[p-1] = 1'b1;
            drops++;
          end
        end else drops++;
      end
      tick();
      if (credit_vld) begin
        total++;
        if (credit_port == 4'd1 || credit_port == 4'd2) cr[credit_port-1]++;
        else begin bad++; $display("FAIL rnd_credit_port cycle %0d got %0d want 1..2", c, credit_port); end
      end
      total++; if (ovf !== movf) begin bad++; $display("FAIL rnd_ovf cycle %0d got %b want %b", c, ovf, movf); end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (vld[i] !== (mq[i].size() != 0)) begin bad++; $display("FAIL rnd_vld%0d cycle %0d got %b want %b", i, c, vld[i], mq[i].size() != 0); end
        else if (vld[i] && dout[i*32 +: 32] !== mq[i][0]) begin bad++; $display("FAIL rnd_data%0d cycle %0d got %h want %h", i, c, dout[i*32 +: 32], mq[i][0]); end
      end
    end
    din = '0;
    ack = 2'b00;
    repeat (5) begin
      tick();
      if (credit_vld && (credit_port == 4'd1 || credit_port == 4'd2)) cr[credit_port-1]++;
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (cr[i] != cons[i] / 4) begin bad++; $display("FAIL rnd_credits%0d got %0d want %0d", i, cr[i], cons[i] / 4); end
    end
`ifdef LEAF_PACKET_RX_DROP_CNT_EN
    total++; if (drop_cnt !== 16'(drops)) begin bad++; $display("FAIL rnd_drop_cnt got %0d want %0d", drop_cnt, drops); end
`else
    if (drops < 0) $display("drops %0d", drops);
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_overflow();
    test_full_pushpop();
    test_credit_pair();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
